// File: rtl/tt_scan_pkg.sv
// Shared types and constants for the truth-table scanner.
package tt_scan_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int N_IN_DEF = 4;
  localparam int TT_W = 2 ** N_IN_DEF;
  localparam logic [TT_W-1:0] EXPECTED_DEF = 16'hDF03;

  // Counter must hold SETTLE-1; a width of at least 1 keeps the vectors legal.
  function automatic int settle_cnt_w(input int settle);
    return (settle < 2) ? 1 : $clog2(settle + 1);
  endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Loadable down-counter with a zero flag; paces how long each vector is held.
module tt_settle_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/truth_table_scanner.sv
// Sweeps every input vector through F, captures the truth table and compares it.
// Optional TT_SCAN_FIRST_FAIL_EN adds first-failing-vector reporting.
module truth_table_scanner
  import tt_scan_pkg::*;
#(
  parameter int                  N_IN     = N_IN_DEF,
  parameter int                  SETTLE   = 1,
  parameter logic [2**N_IN-1:0]  EXPECTED = EXPECTED_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                f_in,
  output logic [N_IN-1:0]     vec_out,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [2**N_IN-1:0]  table_out,
`ifdef TT_SCAN_FIRST_FAIL_EN
  output logic                first_fail_valid,
  output logic [N_IN-1:0]     first_fail_idx,
`endif
  output logic [1:0]          o_dbg_state
);

  localparam int TW = 2 ** N_IN;
  localparam int CW = settle_cnt_w(SETTLE);
  localparam logic [CW-1:0] LOAD_V = CW'(SETTLE - 1);

  if (SETTLE < 1) begin : g_settle_chk
    $error("truth_table_scanner: SETTLE must be at least 1");
  end

  state_t          r_state;
  state_t          w_state_next;
  logic [N_IN-1:0] r_vec;
  logic [TW-1:0]   r_table;
  logic [TW-1:0]   w_table_next;
  logic            r_pass;
  logic            w_load;
  logic            w_dec;
  logic            w_zero;
  logic            w_last;

  tt_settle_timer #(.W(CW)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_load_val (LOAD_V),
    .i_dec      (w_dec),
    .o_zero     (w_zero)
  );

  assign w_last = (r_vec == {N_IN{1'b1}});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_dec        = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_next = DRIVE;
          w_load       = 1'b1;
        end
      end
      DRIVE: begin
        if (w_zero) w_state_next = SAMPLE;
        else        w_dec        = 1'b1;
      end
      SAMPLE: begin
        if (w_last) begin
          w_state_next = DONE;
        end else begin
          w_state_next = DRIVE;
          w_load       = 1'b1;
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // The table as it will look after this SAMPLE; the pass compare uses it so
  // the final vector's bit is included.
  always_comb begin
    w_table_next        = r_table;
    w_table_next[r_vec] = f_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vec   <= '0;
      r_table <= '0;
      r_pass  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_vec   <= '0;
            r_table <= '0;
            r_pass  <= 1'b0;
          end
        end
        SAMPLE: begin
          r_table <= w_table_next;
          if (w_last) r_pass <= (w_table_next == EXPECTED);
          else        r_vec  <= r_vec + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef TT_SCAN_FIRST_FAIL_EN
  logic            r_ff_valid;
  logic [N_IN-1:0] r_ff_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ff_valid <= 1'b0;
      r_ff_idx   <= '0;
    end else if ((r_state == IDLE) && start) begin
      r_ff_valid <= 1'b0;
      r_ff_idx   <= '0;
    end else if ((r_state == SAMPLE) && !r_ff_valid && (f_in != EXPECTED[r_vec])) begin
      r_ff_valid <= 1'b1;
      r_ff_idx   <= r_vec;
    end
  end

  assign first_fail_valid = r_ff_valid;
  assign first_fail_idx   = r_ff_idx;
`endif

  assign vec_out     = r_vec;
  assign table_out   = r_table;
  assign pass        = r_pass;
  assign busy        = (r_state != IDLE);
  assign done        = (r_state == DONE);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_truth_table_scanner.sv
// Directed bench for truth_table_scanner (SETTLE=1 and SETTLE=3 instances).
// Checks first-fail ports when TT_SCAN_FIRST_FAIL_EN is defined.
module tb_truth_table_scanner;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        start3 = 1'b0;
  logic        f_in, f_in3;
  logic [3:0]  vec_out, vec_out3;
  logic        busy, busy3, done, done3, pass, pass3;
  logic [15:0] table_out, table_out3;
  logic [1:0]  dbg_state, dbg_state3;
`ifdef TT_SCAN_FIRST_FAIL_EN
  logic        ffv, ffv3;
  logic [3:0]  ffi, ffi3;
`endif

  logic [15:0] gold    = 16'hDF03;
  logic [15:0] minus12 = 16'hCF03;
  int          mode = 0;  // 0 golden F, 1 stuck at 0, 2 minterm 12 removed

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  always_comb begin
    case (mode)
      1:       begin f_in = 1'b0;             f_in3 = 1'b0;              end
      2:       begin f_in = minus12[vec_out]; f_in3 = minus12[vec_out3]; end
      default: begin f_in = gold[vec_out];    f_in3 = gold[vec_out3];    end
    endcase
  end

  truth_table_scanner #(.N_IN(4), .SETTLE(1), .EXPECTED(16'hDF03)) dut (
    .clk(clk), .rst(rst), .start(start), .f_in(f_in),
    .vec_out(vec_out), .busy(busy), .done(done), .pass(pass),
    .table_out(table_out),
`ifdef TT_SCAN_FIRST_FAIL_EN
    .first_fail_valid(ffv), .first_fail_idx(ffi),
`endif
    .o_dbg_state(dbg_state)
  );

  truth_table_scanner #(.N_IN(4), .SETTLE(3), .EXPECTED(16'hDF03)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .f_in(f_in3),
    .vec_out(vec_out3), .busy(busy3), .done(done3), .pass(pass3),
    .table_out(table_out3),
`ifdef TT_SCAN_FIRST_FAIL_EN
    .first_fail_valid(ffv3), .first_fail_idx(ffi3),
`endif
    .o_dbg_state(dbg_state3)
  );

  // One scan on the SETTLE=1 instance; optionally re-pulses start at vector 3,
  // vector 15 and during DONE.
  task automatic run_scan(input bit repulse, output int done_edge,
                          output int done_cnt, output int seq_errs);
    int exp_vec;
    done_edge = -1;
    done_cnt  = 0;
    seq_errs  = 0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    if (vec_out !== 4'd0 || busy !== 1'b1) seq_errs++;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_edge < 0) done_edge = n;
      end
      exp_vec = (n < 32) ? n / 2 : 15;
      if (n <= 32 && (vec_out !== 4'(exp_vec) || busy !== 1'b1)) seq_errs++;
      if (n > 33 && busy !== 1'b0) seq_errs++;
      start = repulse && (n == 6 || n == 30 || n == 32);
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    #2; rst = 1'b1; start = 1'b1; start3 = 1'b1;
    #1;
    checks++;
    if (vec_out !== 4'd0 || busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 ||
        table_out !== 16'h0000 || dbg_state !== 2'd0) begin
      failures++;
      $display("FAIL reset_async: vec=%0h busy=%b done=%b pass=%b table=%h st=%0d, required all 0",
               vec_out, busy, done, pass, table_out, dbg_state);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || busy3 !== 1'b0 || vec_out3 !== 4'd0 || table_out3 !== 16'h0000) begin
      failures++;
      $display("FAIL reset_start_ignored: busy=%b busy3=%b vec3=%0h table3=%h, required 0",
               busy, busy3, vec_out3, table_out3);
    end
`ifdef TT_SCAN_FIRST_FAIL_EN
    checks++;
    if (ffv !== 1'b0 || ffi !== 4'd0) begin
      failures++;
      $display("FAIL reset_first_fail: valid=%b idx=%0d, required 0 0", ffv, ffi);
    end
`endif
    @(negedge clk); rst = 1'b0; start = 1'b0; start3 = 1'b0;
  endtask

  task automatic test_golden;
    int de, dc, se;
    mode = 0;
    run_scan(1'b0, de, dc, se);
    checks++;
    if (se != 0) begin
      failures++;
      $display("FAIL golden_sequence: errors=%0d, required 0", se);
    end
    checks++;
    if (de != 32 || dc != 1) begin
      failures++;
      $display("FAIL golden_done: edge=%0d count=%0d, required 32 1", de, dc);
    end
    checks++;
    if (table_out !== 16'hDF03 || pass !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL golden_result: table=%h pass=%b busy=%b, required DF03 1 0",
               table_out, pass, busy);
    end
`ifdef TT_SCAN_FIRST_FAIL_EN
    checks++;
    if (ffv !== 1'b0) begin
      failures++;
      $display("FAIL golden_first_fail: valid=%b, required 0", ffv);
    end
`endif
  endtask

  task automatic test_stuck_zero;
    int de, dc, se;
    mode = 1;
    run_scan(1'b0, de, dc, se);
    checks++;
    if (table_out !== 16'h0000 || pass !== 1'b0 || de != 32) begin
      failures++;
      $display("FAIL stuck0_result: table=%h pass=%b done_edge=%0d, required 0000 0 32",
               table_out, pass, de);
    end
`ifdef TT_SCAN_FIRST_FAIL_EN
    checks++;
    if (ffv !== 1'b1 || ffi !== 4'd0) begin
      failures++;
      $display("FAIL stuck0_first_fail: valid=%b idx=%0d, required 1 0", ffv, ffi);
    end
`endif
  endtask

  task automatic test_minus12;
    int de, dc, se;
    mode = 2;
    run_scan(1'b0, de, dc, se);
    checks++;
    if (table_out !== 16'hCF03 || pass !== 1'b0 || se != 0) begin
      failures++;
      $display("FAIL minus12_result: table=%h pass=%b seq_errs=%0d, required CF03 0 0",
               table_out, pass, se);
    end
`ifdef TT_SCAN_FIRST_FAIL_EN
    checks++;
    if (ffv !== 1'b1 || ffi !== 4'd12) begin
      failures++;
      $display("FAIL minus12_first_fail: valid=%b idx=%0d, required 1 12", ffv, ffi);
    end
`endif
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (table_out !== 16'hCF03 || pass !== 1'b0 || vec_out !== 4'd15) begin
      failures++;
      $display("FAIL minus12_hold: table=%h pass=%b vec=%0d, required CF03 0 15",
               table_out, pass, vec_out);
    end
  endtask

  task automatic test_restart_ignored;
    int de, dc, se;
    mode = 0;
    run_scan(1'b1, de, dc, se);
    checks++;
    if (se != 0 || de != 32 || dc != 1) begin
      failures++;
      $display("FAIL restart_ignored: seq_errs=%0d done_edge=%0d done_count=%0d, required 0 32 1",
               se, de, dc);
    end
    checks++;
    if (pass !== 1'b1 || table_out !== 16'hDF03) begin
      failures++;
      $display("FAIL restart_result: table=%h pass=%b, required DF03 1", table_out, pass);
    end
  endtask

  task automatic test_reset_mid_scan;
    int de, dc, se;
    mode = 1;  // leaves pass=0 so a clean rescan has to set it
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    mode = 0;
    repeat (14) @(posedge clk);
    #1;
    checks++;
    if (vec_out !== 4'd7 || busy !== 1'b1) begin
      failures++;
      $display("FAIL midscan_position: vec=%0d busy=%b, required 7 1", vec_out, busy);
    end
    #2; rst = 1'b1;
    #1;
    checks++;
    if (vec_out !== 4'd0 || busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 ||
        table_out !== 16'h0000 || dbg_state !== 2'd0) begin
      failures++;
      $display("FAIL midscan_reset: vec=%0d busy=%b done=%b pass=%b table=%h st=%0d, required all 0",
               vec_out, busy, done, pass, table_out, dbg_state);
    end
    @(negedge clk); rst = 1'b0;
    run_scan(1'b0, de, dc, se);
    checks++;
    if (se != 0 || de != 32 || pass !== 1'b1 || table_out !== 16'hDF03) begin
      failures++;
      $display("FAIL midscan_rescan: seq_errs=%0d done_edge=%0d pass=%b table=%h, required 0 32 1 DF03",
               se, de, pass, table_out);
    end
  endtask

  task automatic test_settle3;
    int done_edge = -1;
    int done_cnt = 0;
    int seq_errs = 0;
    int exp_vec;
    mode = 0;
    @(negedge clk); start3 = 1'b1;
    @(posedge clk); #1; start3 = 1'b0;
    if (vec_out3 !== 4'd0 || busy3 !== 1'b1) seq_errs++;
    for (int n = 1; n <= 72; n++) begin
      @(posedge clk); #1;
      if (done3 === 1'b1) begin
        done_cnt++;
        if (done_edge < 0) done_edge = n;
      end
      exp_vec = (n < 64) ? n / 4 : 15;
      if (n <= 64 && (vec_out3 !== 4'(exp_vec) || busy3 !== 1'b1)) seq_errs++;
      if (n > 65 && busy3 !== 1'b0) seq_errs++;
    end
    checks++;
    if (seq_errs != 0) begin
      failures++;
      $display("FAIL settle3_sequence: errors=%0d, required 0", seq_errs);
    end
    checks++;
    if (done_edge != 64 || done_cnt != 1) begin
      failures++;
      $display("FAIL settle3_done: edge=%0d count=%0d, required 64 1", done_edge, done_cnt);
    end
    checks++;
    if (table_out3 !== 16'hDF03 || pass3 !== 1'b1) begin
      failures++;
      $display("FAIL settle3_result: table=%h pass=%b, required DF03 1", table_out3, pass3);
    end
  endtask

  initial begin
    test_reset();
    test_golden();
    test_stuck_zero();
    test_minus12();
    test_restart_ignored();
    test_reset_mid_scan();
    test_settle3();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
